ble_packet_sequencer: RTL and testbench

- Sequences the 256-entry, 1-bit BLE packet ROM into a serial bit stream for the FSK modulator.
- Drives the ROM address and holds each ROM bit for a programmable number of clock cycles (one symbol).
- Replays the packet a programmable number of times, with an idle gap between passes.
- Provides a start/stop/busy/done control handshake to the top-level TX controller.

---
 rtl/ble_seq_if.sv | 26 ++
 rtl/ble_packet_sequencer.sv | 156 +++++++++++++++
 tb/tb_ble_packet_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ble_seq_if.sv
// Control, ROM and serial-output signals between the TX controller side and the packet sequencer.
interface ble_seq_if;
  logic       start;
  logic       stop;
  logic [7:0] repeat_count;
  logic [7:0] rom_addr;
  logic       rom_data;
  logic       tx_bit;
  logic       tx_valid;
  logic       sym_strobe;
  logic       busy;
  logic       done;
  logic [7:0] pass_cnt;

  // Environment side: TX controller plus packet ROM
  modport master (
    output start, stop, repeat_count, rom_data,
    input  rom_addr, tx_bit, tx_valid, sym_strobe, busy, done, pass_cnt
  );

  // Sequencer side
  modport slave (
    input  start, stop, repeat_count, rom_data,
    output rom_addr, tx_bit, tx_valid, sym_strobe, busy, done, pass_cnt
  );
endinterface

// File: rtl/ble_packet_sequencer.sv
// Walks the 1-bit packet ROM, holding each bit for SPS cycles, replaying the
// packet repeat_count times with an optional idle gap between passes.
module ble_packet_sequencer #(
  parameter int unsigned SPS         = 16,
  parameter int unsigned PKT_LEN     = 256,
  parameter int unsigned GAP_SYMBOLS = 32
) (
  input  logic     clk,
  input  logic     rst,
  ble_seq_if.slave bus
);

  localparam int unsigned SYM_W     = $clog2(SPS);
  localparam int unsigned GAP_W     = $clog2(255 * SPS + 1);
  localparam int unsigned GAP_LAST  = (GAP_SYMBOLS == 0) ? 0 : GAP_SYMBOLS * SPS - 1;
  localparam logic [7:0]  ADDR_LAST = 8'(PKT_LEN - 1);

  typedef enum logic [1:0] {IDLE, TX, GAP, DONE} state_e;

  state_e             state_q, state_d;
  logic [7:0]         rom_addr_q, rom_addr_d;
  logic [SYM_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]         reps_q, reps_d;
  logic [7:0]         pass_cnt_q, pass_cnt_d;
  logic               tx_bit_q, tx_bit_d;
  logic               tx_valid_q, tx_valid_d;
  logic               sym_strobe_q, sym_strobe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sym_last_c;

  assign sym_last_c = (sym_cnt_q == SYM_W'(SPS - 1));

  // Next-state and counter logic; stop overrides every other transition
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    sym_cnt_d  = sym_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    reps_d     = reps_q;
    pass_cnt_d = pass_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          reps_d     = (bus.repeat_count == 8'd0) ? 8'd1 : bus.repeat_count;
          rom_addr_d = 8'd0;
          sym_cnt_d  = '0;
          gap_cnt_d  = '0;
          pass_cnt_d = 8'd0;
          state_d    = TX;
        end
      end
      TX: begin
        if (sym_last_c) begin
          sym_cnt_d = '0;
          if (rom_addr_q == ADDR_LAST) begin
            // Explicit wrap at the end of a pass
            rom_addr_d = 8'd0;
            pass_cnt_d = pass_cnt_q + 8'd1;
            if ((pass_cnt_q + 8'd1) == reps_q) begin
              state_d = DONE;
            end else if (GAP_SYMBOLS == 0) begin
              state_d = TX;
            end else begin
              gap_cnt_d = '0;
              state_d   = GAP;
            end
          end else begin
            rom_addr_d = rom_addr_q + 8'd1;
          end
        end else begin
          sym_cnt_d = sym_cnt_q + SYM_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          gap_cnt_d = '0;
          sym_cnt_d = '0;
          state_d   = TX;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q != IDLE) && bus.stop) begin
      state_d    = IDLE;
      rom_addr_d = 8'd0;
      sym_cnt_d  = '0;
      gap_cnt_d  = '0;
      pass_cnt_d = pass_cnt_q;
    end
  end

  // Output pipeline: one cycle from rom_addr to tx_bit
  always_comb begin
    tx_bit_d     = 1'b0;
    tx_valid_d   = 1'b0;
    sym_strobe_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    if (state_q == TX) begin
      tx_bit_d     = bus.rom_data;
      tx_valid_d   = 1'b1;
      sym_strobe_d = (sym_cnt_q == '0);
    end
    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE) && !bus.stop;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rom_addr_q   <= 8'd0;
      sym_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      reps_q       <= 8'd0;
      pass_cnt_q   <= 8'd0;
      tx_bit_q     <= 1'b0;
      tx_valid_q   <= 1'b0;
      sym_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      sym_cnt_q    <= sym_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      reps_q       <= reps_d;
      pass_cnt_q   <= pass_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_valid_q   <= tx_valid_d;
      sym_strobe_q <= sym_strobe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.tx_bit     = tx_bit_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.sym_strobe = sym_strobe_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass_cnt   = pass_cnt_q;

endmodule

// File: tb/tb_ble_packet_sequencer.sv
// Directed bench: two sequencers (SPS=4, 256-bit packet), one with a 2-symbol gap, one gapless.
module tb_ble_packet_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ble_seq_if a_if ();
  ble_seq_if b_if ();

  // Packet ROM: preamble 0101010101, then 1,0, parity filler, last bit 1
  function automatic logic rom_bit(input logic [7:0] a);
    if (a < 8'd10)       return a[0];
    else if (a == 8'd10) return 1'b1;
    else if (a == 8'd11) return 1'b0;
    else if (a == 8'd255) return 1'b1;
    else                 return ^a;
  endfunction

  assign a_if.rom_data = rom_bit(a_if.rom_addr);
  assign b_if.rom_data = rom_bit(b_if.rom_addr);

  ble_packet_sequencer #(.SPS(4), .PKT_LEN(256), .GAP_SYMBOLS(2)) u_gap (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  ble_packet_sequencer #(.SPS(4), .PKT_LEN(256), .GAP_SYMBOLS(0)) u_nogap (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Run statistics filled by measure()
  int         n_valid, first_valid, last_valid, n_strobe, strobe_err;
  int         n_done, done_cyc, busy_fall_cyc, bit_err, n_gaps, n_pc;
  int         gap_len [4];
  logic [7:0] pc_hist [4];
  logic [11:0] first12;
  logic       last_bit, wrap_hi, wrap_lo;
  logic [7:0] final_pc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit sel, input logic [7:0] rc);
    if (sel) begin b_if.start = 1'b1; b_if.repeat_count = rc; end
    else     begin a_if.start = 1'b1; a_if.repeat_count = rc; end
    step();
    a_if.start = 1'b0;
    b_if.start = 1'b0;
  endtask

  // Observe ncyc cycles starting at cycle 1 of a run; optionally pulse start at inj_cyc
  task automatic measure(input bit sel, input int ncyc, input int inj_cyc);
    logic v, bt, s, d, bz;
    logic [7:0] pc, pc_prev;
    int zero_run;
    bit seen_valid;
    n_valid = 0; first_valid = -1; last_valid = -1; n_strobe = 0; strobe_err = 0;
    n_done = 0; done_cyc = -1; busy_fall_cyc = -1; bit_err = 0; n_gaps = 0; n_pc = 0;
    first12 = '0; last_bit = 1'bx; wrap_hi = 1'bx; wrap_lo = 1'bx;
    for (int i = 0; i < 4; i++) begin gap_len[i] = -1; pc_hist[i] = 8'hxx; end
    pc_prev = 8'd0; zero_run = 0; seen_valid = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (sel) begin
        v = b_if.tx_valid; bt = b_if.tx_bit; s = b_if.sym_strobe;
        d = b_if.done; bz = b_if.busy; pc = b_if.pass_cnt;
      end else begin
        v = a_if.tx_valid; bt = a_if.tx_bit; s = a_if.sym_strobe;
        d = a_if.done; bz = a_if.busy; pc = a_if.pass_cnt;
      end
      if (s) begin
        n_strobe++;
        if (!(v && (n_valid % 4 == 0))) strobe_err++;
      end
      if (v) begin
        if (seen_valid && zero_run > 0) begin
          if (n_gaps < 4) gap_len[n_gaps] = zero_run;
          n_gaps++;
        end
        zero_run = 0;
        seen_valid = 1'b1;
        if (first_valid < 0) first_valid = c;
        last_valid = c;
        if (bt !== rom_bit(8'((n_valid / 4) % 256))) bit_err++;
        if (n_valid < 48 && (n_valid % 4 == 0)) first12[n_valid / 4] = bt;
        if (n_valid == 1023) wrap_hi = bt;
        if (n_valid == 1024) wrap_lo = bt;
        last_bit = bt;
        n_valid++;
      end else if (seen_valid) begin
        zero_run++;
      end
      if (d) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (!bz && busy_fall_cyc < 0) busy_fall_cyc = c;
      if (pc !== pc_prev) begin
        if (n_pc < 4) pc_hist[n_pc] = pc;
        n_pc++;
        pc_prev = pc;
      end
      final_pc = pc;
      if (c == inj_cyc) begin
        if (sel) begin b_if.start = 1'b1; b_if.repeat_count = 8'd7; end
        else     begin a_if.start = 1'b1; a_if.repeat_count = 8'd7; end
      end
      step();
      a_if.start = 1'b0;
      b_if.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step(); step();
    total++;
    if ({a_if.rom_addr, a_if.tx_bit, a_if.tx_valid, a_if.sym_strobe, a_if.busy, a_if.done, a_if.pass_cnt} !== 21'd0) begin
      bad++; $display("FAIL reset_gap_outputs got=%h exp=0", {a_if.rom_addr, a_if.tx_bit, a_if.tx_valid, a_if.sym_strobe, a_if.busy, a_if.done, a_if.pass_cnt});
    end
    total++;
    if ({b_if.rom_addr, b_if.tx_bit, b_if.tx_valid, b_if.sym_strobe, b_if.busy, b_if.done, b_if.pass_cnt} !== 21'd0) begin
      bad++; $display("FAIL reset_nogap_outputs got=%h exp=0", {b_if.rom_addr, b_if.tx_bit, b_if.tx_valid, b_if.sym_strobe, b_if.busy, b_if.done, b_if.pass_cnt});
    end
    rst = 1'b0;
    step();
  endtask

  // Common single-pass expectations (scenario 1 timing)
  task automatic check_single(input string tag);
    total++; if (n_valid !== 1024) begin bad++; $display("FAIL %s valid_count got=%0d exp=1024", tag, n_valid); end
    total++; if (first_valid !== 2 || last_valid !== 1025) begin bad++; $display("FAIL %s valid_window got=%0d..%0d exp=2..1025", tag, first_valid, last_valid); end
    total++; if (n_gaps !== 0) begin bad++; $display("FAIL %s gaps got=%0d exp=0", tag, n_gaps); end
    total++; if (done_cyc !== 1026 || n_done !== 1) begin bad++; $display("FAIL %s done got=cyc%0d/n%0d exp=cyc1026/n1", tag, done_cyc, n_done); end
    total++; if (busy_fall_cyc !== 1026) begin bad++; $display("FAIL %s busy_fall got=%0d exp=1026", tag, busy_fall_cyc); end
    total++; if (final_pc !== 8'd1) begin bad++; $display("FAIL %s pass_cnt got=%0d exp=1", tag, final_pc); end
  endtask

  task automatic test_single_pass();
    pulse_start(1'b0, 8'd1);
    total++; if (a_if.rom_addr !== 8'd0 || a_if.busy !== 1'b1 || a_if.tx_valid !== 1'b0) begin
      bad++; $display("FAIL s1_cycle1 got=addr%0d/busy%b/valid%b exp=addr0/busy1/valid0", a_if.rom_addr, a_if.busy, a_if.tx_valid);
    end
    measure(1'b0, 1030, -1);
    check_single("s1");
    total++; if (first12 !== 12'h6AA) begin bad++; $display("FAIL s1_first12 got=%h exp=6aa", first12); end
    total++; if (last_bit !== 1'b1) begin bad++; $display("FAIL s1_last_bit got=%b exp=1", last_bit); end
    total++; if (bit_err !== 0) begin bad++; $display("FAIL s1_bit_stream got=%0d errors exp=0", bit_err); end
    total++; if (n_strobe !== 256 || strobe_err !== 0) begin bad++; $display("FAIL s1_strobe got=%0d/err%0d exp=256/err0", n_strobe, strobe_err); end
  endtask

  task automatic test_repeat();
    pulse_start(1'b0, 8'd0);
    measure(1'b0, 1030, -1);
    check_single("s2_rc0");
    pulse_start(1'b0, 8'd3);
    measure(1'b0, 3100, -1);
    total++; if (n_valid !== 3072) begin bad++; $display("FAIL s2_valid_count got=%0d exp=3072", n_valid); end
    total++; if (n_gaps !== 2 || gap_len[0] !== 8 || gap_len[1] !== 8) begin
      bad++; $display("FAIL s2_gaps got=n%0d/%0d/%0d exp=n2/8/8", n_gaps, gap_len[0], gap_len[1]);
    end
    total++; if (first_valid !== 2 || last_valid !== 3089) begin bad++; $display("FAIL s2_window got=%0d..%0d exp=2..3089", first_valid, last_valid); end
    total++; if (n_pc !== 3 || pc_hist[0] !== 8'd1 || pc_hist[1] !== 8'd2 || pc_hist[2] !== 8'd3) begin
      bad++; $display("FAIL s2_pass_cnt got=n%0d/%0d,%0d,%0d exp=n3/1,2,3", n_pc, pc_hist[0], pc_hist[1], pc_hist[2]);
    end
    total++; if (n_done !== 1 || done_cyc !== 3090) begin bad++; $display("FAIL s2_done got=n%0d/cyc%0d exp=n1/cyc3090", n_done, done_cyc); end
    total++; if (bit_err !== 0 || n_strobe !== 768) begin bad++; $display("FAIL s2_stream got=err%0d/strobe%0d exp=err0/strobe768", bit_err, n_strobe); end
  endtask

  task automatic test_no_gap();
    pulse_start(1'b1, 8'd2);
    measure(1'b1, 2060, -1);
    total++; if (n_valid !== 2048 || n_gaps !== 0) begin bad++; $display("FAIL s3_contiguous got=%0d/gaps%0d exp=2048/gaps0", n_valid, n_gaps); end
    total++; if (first_valid !== 2 || last_valid !== 2049) begin bad++; $display("FAIL s3_window got=%0d..%0d exp=2..2049", first_valid, last_valid); end
    total++; if (wrap_hi !== 1'b1 || wrap_lo !== 1'b0) begin bad++; $display("FAIL s3_wrap_bits got=%b,%b exp=1,0", wrap_hi, wrap_lo); end
    total++; if (bit_err !== 0) begin bad++; $display("FAIL s3_bit_stream got=%0d errors exp=0", bit_err); end
    total++; if (done_cyc !== 2050 || final_pc !== 8'd2) begin bad++; $display("FAIL s3_done got=cyc%0d/pc%0d exp=cyc2050/pc2", done_cyc, final_pc); end
  endtask

  task automatic test_stop();
    int dn;
    pulse_start(1'b0, 8'd2);
    for (int c = 1; c < 1434; c++) step();
    total++; if (a_if.rom_addr !== 8'd100 || a_if.pass_cnt !== 8'd1) begin
      bad++; $display("FAIL s4_pre_stop got=addr%0d/pc%0d exp=addr100/pc1", a_if.rom_addr, a_if.pass_cnt);
    end
    a_if.stop = 1'b1;
    step();
    a_if.stop = 1'b0;
    total++; if (a_if.busy !== 1'b0 || a_if.rom_addr !== 8'd0 || a_if.pass_cnt !== 8'd1) begin
      bad++; $display("FAIL s4_after_stop got=busy%b/addr%0d/pc%0d exp=busy0/addr0/pc1", a_if.busy, a_if.rom_addr, a_if.pass_cnt);
    end
    step();
    total++; if (a_if.tx_valid !== 1'b0) begin bad++; $display("FAIL s4_valid_fall got=%b exp=0", a_if.tx_valid); end
    dn = 0;
    for (int i = 0; i < 20; i++) begin if (a_if.done) dn++; step(); end
    total++; if (dn !== 0) begin bad++; $display("FAIL s4_no_done got=%0d exp=0", dn); end
    pulse_start(1'b0, 8'd1);
    total++; if (a_if.rom_addr !== 8'd0 || a_if.pass_cnt !== 8'd0 || a_if.busy !== 1'b1) begin
      bad++; $display("FAIL s4_restart got=addr%0d/pc%0d/busy%b exp=addr0/pc0/busy1", a_if.rom_addr, a_if.pass_cnt, a_if.busy);
    end
    measure(1'b0, 1030, -1);
    check_single("s4_restart");
  endtask

  task automatic test_start_while_busy();
    pulse_start(1'b0, 8'd1);
    measure(1'b0, 1030, 202);
    check_single("s5");
    total++; if (bit_err !== 0) begin bad++; $display("FAIL s5_bit_stream got=%0d errors exp=0", bit_err); end
  endtask

  task automatic test_rst_and_last_stop();
    int dn;
    pulse_start(1'b0, 8'd3);
    for (int c = 1; c < 1028; c++) step();
    total++; if (a_if.tx_valid !== 1'b0 || a_if.busy !== 1'b1 || a_if.pass_cnt !== 8'd1) begin
      bad++; $display("FAIL s6_in_gap got=valid%b/busy%b/pc%0d exp=valid0/busy1/pc1", a_if.tx_valid, a_if.busy, a_if.pass_cnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({a_if.rom_addr, a_if.tx_bit, a_if.tx_valid, a_if.sym_strobe, a_if.busy, a_if.done, a_if.pass_cnt} !== 21'd0) begin
      bad++; $display("FAIL s6_rst_outputs got=%h exp=0", {a_if.rom_addr, a_if.tx_bit, a_if.tx_valid, a_if.sym_strobe, a_if.busy, a_if.done, a_if.pass_cnt});
    end
    dn = 0;
    for (int i = 0; i < 20; i++) begin if (a_if.done || a_if.busy || a_if.tx_valid) dn++; step(); end
    total++; if (dn !== 0) begin bad++; $display("FAIL s6_rst_quiet got=%0d active cycles exp=0", dn); end

    pulse_start(1'b0, 8'd1);
    for (int c = 1; c < 1024; c++) step();
    total++; if (a_if.rom_addr !== 8'd255) begin bad++; $display("FAIL s6_last_addr got=%0d exp=255", a_if.rom_addr); end
    a_if.stop = 1'b1;
    step();
    a_if.stop = 1'b0;
    total++; if (a_if.busy !== 1'b0 || a_if.pass_cnt !== 8'd0 || a_if.rom_addr !== 8'd0) begin
      bad++; $display("FAIL s6_last_stop got=busy%b/pc%0d/addr%0d exp=busy0/pc0/addr0", a_if.busy, a_if.pass_cnt, a_if.rom_addr);
    end
    step();
    total++; if (a_if.tx_valid !== 1'b0) begin bad++; $display("FAIL s6_last_valid_fall got=%b exp=0", a_if.tx_valid); end
    dn = 0;
    for (int i = 0; i < 10; i++) begin if (a_if.done) dn++; step(); end
    total++; if (dn !== 0) begin bad++; $display("FAIL s6_last_no_done got=%0d exp=0", dn); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    a_if.start = 1'b0; a_if.stop = 1'b0; a_if.repeat_count = 8'd0;
    b_if.start = 1'b0; b_if.stop = 1'b0; b_if.repeat_count = 8'd0;
    test_reset();
    test_single_pass();
    test_repeat();
    test_no_gap();
    test_stop();
    test_start_while_busy();
    test_rst_and_last_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
